transfer_sequencer: RTL



---
 rtl/register_transfer_pkg.sv | 42 ++++
 rtl/transfer_sequencer_if.sv | 37 +++
 rtl/transfer_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/register_transfer_pkg.sv
// Shared types and constants for the two-register transfer sequencer
// and the datapath it controls.
package register_transfer_pkg;

    localparam int DEFAULT_WORD_LENGTH = 8;

    typedef enum logic [2:0] {
        OP_LOAD_A = 3'b000,
        OP_LOAD_B = 3'b001,
        OP_MOV_AB = 3'b010,
        OP_MOV_BA = 3'b011,
        OP_READ_A = 3'b100,
        OP_READ_B = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_COMMIT,
        ST_VERIFY,
        ST_RESP
    } state_e;

    localparam logic SEL_EXT  = 1'b0;
    localparam logic SEL_BUS  = 1'b1;
    localparam logic OE_DRV_A = 1'b0;
    localparam logic OE_DRV_B = 1'b1;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'b101;
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_READ_A) || (op == OP_READ_B);
    endfunction

    // Register whose contents the transfer is judged by.
    function automatic logic op_dest_is_a(input logic [2:0] op);
        return (op == OP_LOAD_A) || (op == OP_MOV_BA) || (op == OP_READ_A);
    endfunction

endpackage

// File: rtl/transfer_sequencer_if.sv
// Command, response and datapath-control signals of the transfer sequencer.
// master = sequencer side, slave = command source plus datapath.
interface transfer_sequencer_if
    import register_transfer_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_op;
    logic [WORD_LENGTH-1:0] cmd_data;

    logic [WORD_LENGTH-1:0] DA;
    logic [WORD_LENGTH-1:0] DB;
    logic                   Sel_A;
    logic                   Sel_B;
    logic                   OE_A;
    logic                   enable;
    logic [WORD_LENGTH-1:0] bus_in;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WORD_LENGTH-1:0] rsp_data;
    logic                   rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, bus_in, rsp_ready,
        output cmd_ready, DA, DB, Sel_A, Sel_B, OE_A, enable,
        output rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, bus_in, rsp_ready,
        input  cmd_ready, DA, DB, Sel_A, Sel_B, OE_A, enable,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/transfer_sequencer.sv
// Sequences register-transfer commands onto the file-register datapath,
// tracks expected register contents and checks the bus read-back.
module transfer_sequencer
    import register_transfer_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    transfer_sequencer_if.master  io
);
    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [WORD_LENGTH-1:0] sh_a_q, sh_a_d;
    logic [WORD_LENGTH-1:0] sh_b_q, sh_b_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [WORD_LENGTH-1:0] da_q, da_d;
    logic [WORD_LENGTH-1:0] db_q, db_d;
    logic                   sel_a_q, sel_a_d;
    logic                   sel_b_q, sel_b_d;
    logic                   oe_a_q, oe_a_d;
    logic                   enable_q, enable_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WORD_LENGTH-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        cmd_ready_d = cmd_ready_q;
        da_d        = da_q;
        db_d        = db_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        oe_a_d      = oe_a_q;
        enable_d    = enable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                enable_d    = 1'b0;
                if (io.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = io.cmd_op;
                    data_d      = io.cmd_data;
                    state_d     = ST_DRIVE;
                    // Non-target register reloads its own shadow through the external input.
                    sel_a_d     = SEL_EXT;
                    sel_b_d     = SEL_EXT;
                    da_d        = sh_a_q;
                    db_d        = sh_b_q;
                    case (io.cmd_op)
                        OP_LOAD_A: da_d = io.cmd_data;
                        OP_LOAD_B: db_d = io.cmd_data;
                        OP_MOV_AB: begin
                            oe_a_d  = OE_DRV_A;
                            sel_b_d = SEL_BUS;
                        end
                        OP_MOV_BA: begin
                            oe_a_d  = OE_DRV_B;
                            sel_a_d = SEL_BUS;
                        end
                        OP_READ_A: oe_a_d = OE_DRV_A;
                        OP_READ_B: oe_a_d = OE_DRV_B;
                        default: ;
                    endcase
                end
            end

            ST_DRIVE: begin
                if (!op_is_legal(op_q)) begin
                    // Illegal ops pass through DRIVE untouched so the error lands one edge after accept.
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else if (op_is_read(op_q)) begin
                    state_d = ST_VERIFY;
                end else begin
                    state_d  = ST_COMMIT;
                    enable_d = 1'b1;
                end
            end

            ST_COMMIT: begin
                enable_d = 1'b0;
                state_d  = ST_VERIFY;
                oe_a_d   = op_dest_is_a(op_q) ? OE_DRV_A : OE_DRV_B;
                case (op_q)
                    OP_LOAD_A: sh_a_d = data_q;
                    OP_LOAD_B: sh_b_d = data_q;
                    OP_MOV_AB: sh_b_d = sh_a_q;
                    OP_MOV_BA: sh_a_d = sh_b_q;
                    default: ;
                endcase
            end

            ST_VERIFY: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = io.bus_in;
                rsp_err_d   = io.bus_in != (op_dest_is_a(op_q) ? sh_a_q : sh_b_q);
            end

            ST_RESP: begin
                if (io.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cmd_ready_q <= 1'b0;
            da_q        <= '0;
            db_q        <= '0;
            sel_a_q     <= SEL_EXT;
            sel_b_q     <= SEL_EXT;
            oe_a_q      <= OE_DRV_A;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            cmd_ready_q <= cmd_ready_d;
            da_q        <= da_d;
            db_q        <= db_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            oe_a_q      <= oe_a_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign io.cmd_ready = cmd_ready_q;
    assign io.DA        = da_q;
    assign io.DB        = db_q;
    assign io.Sel_A     = sel_a_q;
    assign io.Sel_B     = sel_b_q;
    assign io.OE_A      = oe_a_q;
    assign io.enable    = enable_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_data  = rsp_data_q;
    assign io.rsp_err   = rsp_err_q;

endmodule
